// File: rtl/s_cell_array.sv
// s_cell_array
// Multi-lane S-type sequential cell with a programmable register mode per lane.
// Each lane picks one of four data words using s1 = A1|B1, s0 = A0. On an
// update edge it loads, holds, toggles or accumulates that word into its
// output register. The per-lane modes sit in a serial configuration chain.
//
// Ports:
//   clk                 rising-edge clock
//   clr                 asynchronous active-high clear of all state
//   en                  update enable for the lane registers
//   D00/D01/D10/D11     flattened per-lane data candidates (lane c at [c*WIDTH +: WIDTH])
//   A1, B1, A0          per-lane select terms
//   cfg_en, cfg_in      configuration chain shift enable and serial input
//   cfg_out             chain LSB (mode[0][0])
//   out                 registered lane outputs
//   ovf                 sticky accumulate-overflow flags
module s_cell_array #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] D00,
    input  logic [CHANNELS*WIDTH-1:0] D01,
    input  logic [CHANNELS*WIDTH-1:0] D10,
    input  logic [CHANNELS*WIDTH-1:0] D11,
    input  logic [CHANNELS-1:0]       A1,
    input  logic [CHANNELS-1:0]       B1,
    input  logic [CHANNELS-1:0]       A0,
    input  logic                      cfg_en,
    input  logic                      cfg_in,
    output logic                      cfg_out,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       ovf
);

    localparam int CFG_W = CHANNELS + CHANNELS;

    localparam logic [1:0] MODE_LOAD   = 2'd0;
    localparam logic [1:0] MODE_HOLD   = 2'd1;
    localparam logic [1:0] MODE_TOGGLE = 2'd2;
    localparam logic [1:0] MODE_ACCUM  = 2'd3;

    logic [CFG_W-1:0] cfg_chain_r;
    logic             update_s;

    // Shifting the chain takes priority, so lane registers only update when no shift is in progress.
    assign update_s = en & ~cfg_en;

    // Configuration chain: shift right on cfg_en with cfg_in entering at the MSB.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cfg_chain_r <= {CFG_W{1'b0}};
        end else if (cfg_en) begin
            cfg_chain_r <= {cfg_in, cfg_chain_r[CFG_W-1:1]};
        end else begin
            cfg_chain_r <= cfg_chain_r;
        end
    end

    assign cfg_out = cfg_chain_r[0];

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_lane
            logic [1:0]       sel_s;
            logic [1:0]       mode_s;
            logic [WIDTH-1:0] d_s;
            logic [WIDTH:0]   sum_s;
            logic [WIDTH-1:0] out_nxt_s;
            logic             ovf_nxt_s;
            logic [WIDTH-1:0] out_r;
            logic             ovf_r;

            assign sel_s  = {A1[c] | B1[c], A0[c]};
            assign mode_s = cfg_chain_r[c + c +: 2];

            // Data select: {s1,s0} picks D00/D01/D10/D11 for this lane.
            always_comb begin
                d_s = D00[c*WIDTH +: WIDTH];
                case (sel_s)
                    2'b00:   d_s = D00[c*WIDTH +: WIDTH];
                    2'b01:   d_s = D01[c*WIDTH +: WIDTH];
                    2'b10:   d_s = D10[c*WIDTH +: WIDTH];
                    2'b11:   d_s = D11[c*WIDTH +: WIDTH];
                    default: d_s = D00[c*WIDTH +: WIDTH];
                endcase
            end

            // The extra MSB of the sum is the carry-out used by the sticky overflow flag.
            assign sum_s = {1'b0, out_r} + {1'b0, d_s};

            // Next-state of the lane register according to its configured mode.
            always_comb begin
                out_nxt_s = out_r;
                ovf_nxt_s = ovf_r;
                case (mode_s)
                    MODE_LOAD: begin
                        out_nxt_s = d_s;
                        ovf_nxt_s = 1'b0;
                    end
                    MODE_HOLD: begin
                        out_nxt_s = out_r;
                        ovf_nxt_s = ovf_r;
                    end
                    MODE_TOGGLE: begin
                        out_nxt_s = out_r ^ d_s;
                        ovf_nxt_s = ovf_r;
                    end
                    MODE_ACCUM: begin
                        out_nxt_s = sum_s[WIDTH-1:0];
                        ovf_nxt_s = ovf_r | sum_s[WIDTH];
                    end
                    default: begin
                        out_nxt_s = out_r;
                        ovf_nxt_s = ovf_r;
                    end
                endcase
            end

            // Lane output and overflow registers, written only on update edges.
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    out_r <= {WIDTH{1'b0}};
                    ovf_r <= 1'b0;
                end else if (update_s) begin
                    out_r <= out_nxt_s;
                    ovf_r <= ovf_nxt_s;
                end else begin
                    out_r <= out_r;
                    ovf_r <= ovf_r;
                end
            end

            assign out[c*WIDTH +: WIDTH] = out_r;
            assign ovf[c]                = ovf_r;
        end
    endgenerate

endmodule

// File: tb/tb_s_cell_array.sv
// Self-checking bench for s_cell_array (WIDTH=8, CHANNELS=4).
// The stimulus side updates a behavioural model at every edge and queues the
// expected state. A separate monitor pops and compares after each edge, and
// also after asynchronous clear events.
module tb_s_cell_array;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int CW = C * W;

    logic          clk = 1'b0;
    logic          clr;
    logic          en;
    logic          cfg_en;
    logic          cfg_in;
    logic          cfg_out;
    logic [CW-1:0] D00, D01, D10, D11;
    logic [CW-1:0] out;
    logic [C-1:0]  A1, B1, A0;
    logic [C-1:0]  ovf;

    always #5 clk = ~clk;

    s_cell_array #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk(clk), .clr(clr), .en(en),
        .D00(D00), .D01(D01), .D10(D10), .D11(D11),
        .A1(A1), .B1(B1), .A0(A0),
        .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfg_out),
        .out(out), .ovf(ovf)
    );

    typedef struct {
        string         name;
        logic [CW-1:0] out;
        logic [C-1:0]  ovf;
        logic          cfg;
    } exp_t;

    exp_t exp_q[$];
    event async_chk;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: lane values as plain numbers, chain as a bit queue (index 0 = LSB).
    logic [W-1:0] out_m [C];
    logic         ovf_m [C];
    bit           chain_q[$];

    function automatic logic [W-1:0] lane_d(int c);
        int sel;
        sel = ((A1[c] | B1[c]) ? 2 : 0) + (A0[c] ? 1 : 0);
        case (sel)
            0:       return D00[c*W +: W];
            1:       return D01[c*W +: W];
            2:       return D10[c*W +: W];
            default: return D11[c*W +: W];
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < C; c++) begin
            out_m[c] = '0;
            ovf_m[c] = 1'b0;
        end
        chain_q.delete();
        for (int i = 0; i < 2*C; i++) chain_q.push_back(1'b0);
    endtask

    task automatic model_edge();
        int m;
        int sum;
        logic [W-1:0] d;
        if (clr) begin
            model_reset();
        end else if (cfg_en) begin
            void'(chain_q.pop_front());
            chain_q.push_back(cfg_in);
        end else if (en) begin
            for (int c = 0; c < C; c++) begin
                m = int'(chain_q[2*c]) + 2 * int'(chain_q[2*c+1]);
                d = lane_d(c);
                case (m)
                    0: begin out_m[c] = d; ovf_m[c] = 1'b0; end
                    1: ;
                    2: out_m[c] = out_m[c] ^ d;
                    default: begin
                        sum = int'(out_m[c]) + int'(d);
                        if (sum >= (1 << W)) ovf_m[c] = 1'b1;
                        out_m[c] = sum[W-1:0];
                    end
                endcase
            end
        end
    endtask

    task automatic push_exp(string nm);
        exp_t e;
        e.name = nm;
        for (int c = 0; c < C; c++) begin
            e.out[c*W +: W] = out_m[c];
            e.ovf[c]        = ovf_m[c];
        end
        e.cfg = chain_q[0];
        exp_q.push_back(e);
    endtask

    // One clock: model the edge with the inputs now applied, queue expectation, advance.
    task automatic step(string nm);
        model_edge();
        push_exp(nm);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous clear mid-cycle, checked immediately, then held across one edge.
    task automatic async_clr(string nm);
        #2;
        clr = 1'b1;
        model_reset();
        #1;
        push_exp(nm);
        -> async_chk;
        step({nm, "_held"});
        clr = 1'b0;
    endtask

    task automatic set_all(logic [W-1:0] v);
        for (int c = 0; c < C; c++) begin
            D00[c*W +: W] = v;
            D01[c*W +: W] = v;
            D10[c*W +: W] = v;
            D11[c*W +: W] = v;
        end
        A1 = '0; B1 = '0; A0 = '0;
    endtask

    task automatic rand_data();
        for (int c = 0; c < C; c++) begin
            D00[c*W +: W] = W'($urandom);
            D01[c*W +: W] = W'($urandom);
            D10[c*W +: W] = W'($urandom);
            D11[c*W +: W] = W'($urandom);
        end
        A1 = C'($urandom); B1 = C'($urandom); A0 = C'($urandom);
    endtask

    task automatic program_chain(logic [2*C-1:0] v);
        cfg_en = 1'b1;
        en     = 1'b1;
        for (int i = 0; i < 2*C; i++) begin
            cfg_in = v[i];
            rand_data();
            step("cfg_shift");
        end
        cfg_en = 1'b0;
    endtask

    // Monitor: after each clock edge (or async clear event) compare every queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or async_chk);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (out !== e.out) begin
                    n_bad++;
                    $display("FAIL %s out: got %h expected %h", e.name, out, e.out);
                end
                n_cmp++;
                if (ovf !== e.ovf) begin
                    n_bad++;
                    $display("FAIL %s ovf: got %b expected %b", e.name, ovf, e.ovf);
                end
                n_cmp++;
                if (cfg_out !== e.cfg) begin
                    n_bad++;
                    $display("FAIL %s cfg_out: got %b expected %b", e.name, cfg_out, e.cfg);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] sel_pat [5];
        int         wait_n;
        sel_pat = '{3'b000, 3'b001, 3'b100, 3'b010, 3'b111};

        clr = 1'b1; en = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0;
        D00 = '0; D01 = '0; D10 = '0; D11 = '0;
        A1 = '0; B1 = '0; A0 = '0;
        #2;
        model_reset();
        push_exp("reset");
        -> async_chk;
        @(negedge clk);
        step("reset_held");
        clr = 1'b0;

        // Select sweep on lane 0 in LOAD mode; one "10" case uses B1 alone.
        en = 1'b1;
        D00[7:0] = 8'h11; D01[7:0] = 8'h22; D10[7:0] = 8'h33; D11[7:0] = 8'h44;
        for (int i = 0; i < 5; i++) begin
            A1[0] = sel_pat[i][2];
            B1[0] = sel_pat[i][1];
            A0[0] = sel_pat[i][0];
            step("select");
        end

        // Modes 0..3 on lanes 0..3 after loading 0x5A everywhere.
        set_all(8'h5A);
        step("load_5a");
        program_chain(8'b11_10_01_00);
        set_all(8'h0F);
        en = 1'b1;
        step("modes_edge1");
        step("modes_edge2");

        // Accumulate wrap and sticky overflow on lane 3.
        D00[31:24] = 8'h78;
        step("acc_to_f0");
        D00[31:24] = 8'h20;
        step("acc_wrap");
        D00[31:24] = 8'h01;
        step("acc_sticky");
        program_chain(8'h00);
        en = 1'b1;
        step("load_clears_ovf");

        // Enable off, then configuration priority over update.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin rand_data(); step("en_off"); end
        en = 1'b1; cfg_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_data(); cfg_in = 1'($urandom); step("cfg_priority");
        end
        cfg_en = 1'b0;

        // Randomized mixed traffic.
        for (int i = 0; i < 200; i++) begin
            rand_data();
            en     = ($urandom_range(0, 3) != 0);
            cfg_en = ($urandom_range(0, 3) == 0);
            cfg_in = 1'($urandom);
            step("random");
        end

        // Clear in the middle of the 5th shift bit after all lanes were set to ACCUM.
        program_chain(8'hFF);
        cfg_en = 1'b1;
        for (int i = 0; i < 4; i++) begin cfg_in = 1'b0; rand_data(); step("partial_shift"); end
        cfg_in = 1'b1;
        async_clr("clr_mid_shift");
        cfg_en = 1'b0; en = 1'b1;
        rand_data(); step("post_clr_load1");
        rand_data(); step("post_clr_load2");

        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 5) begin
            @(negedge clk);
            wait_n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
